// File: rtl/ctrl_stat_pkg.sv
// Shared encodings and parameter limits for the control/status register bank.
// Also provides the elaboration-time range helper used by the top level.
package ctrl_stat_pkg;

    localparam int RD_SEL_W   = 5;
    localparam int RD_DOUT_W  = 16;
    localparam int N_EVT_MAX  = 16;
    localparam int CNT_W_MAX  = 16;
    localparam int CTRL_W_MAX = 32;

    localparam logic [RD_SEL_W-1:0] RD_SEL_STICKY = '0;

    function automatic bit in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/evt_chan.sv
// One event channel: a sticky flag and a saturating, read-to-clear counter.
// sticky_nxt_o exposes the next-state flag so the parent can register srq without a lag.
module evt_chan
    import ctrl_stat_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             cpu_clk,
    input  logic             rst,
    input  logic             evt_i,
    input  logic             clr_i,
    input  logic             rd_clr_i,
    output logic             sticky_o,
    output logic             sticky_nxt_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // A coincident event beats the clear.
        sticky_d = evt_i | (sticky_q & ~clr_i);

        cnt_d = cnt_q;
        if (rd_clr_i) begin
            // The value being read excludes this cycle's event; keep it for the next read.
            cnt_d = evt_i ? CNT_W'(1) : '0;
        end else if (evt_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sticky_o     = sticky_q;
    assign sticky_nxt_o = sticky_d;
    assign cnt_o        = cnt_q;

endmodule

// File: rtl/ctrl_stat_bank.sv
// Control register, interrupt mask, per-event sticky/counter channels and a registered read port.
// Reads sample pre-update state; srq is registered from next-state sticky and mask.
module ctrl_stat_bank
    import ctrl_stat_pkg::*;
#(
    parameter int N_EVT  = 4,
    parameter int CNT_W  = 16,
    parameter int CTRL_W = 16
) (
    input  logic                 cpu_clk,
    input  logic                 rst,
    input  logic                 wr_ctrl,
    input  logic                 wr_mask,
    input  logic                 clr_sticky,
    input  logic [31:0]          tos,
    input  logic [N_EVT-1:0]     evt_in,
    input  logic                 rd_stat,
    input  logic [RD_SEL_W-1:0]  rd_sel,
    output logic [CTRL_W-1:0]    ctrl,
    output logic [RD_DOUT_W-1:0] rd_dout,
    output logic                 srq
);

    if (!in_range(N_EVT, 1, N_EVT_MAX)) begin : g_bad_n_evt
        $error("ctrl_stat_bank: N_EVT out of range 1..16");
    end
    if (!in_range(CNT_W, 1, CNT_W_MAX)) begin : g_bad_cnt_w
        $error("ctrl_stat_bank: CNT_W out of range 1..16");
    end
    if (!in_range(CTRL_W, 1, CTRL_W_MAX)) begin : g_bad_ctrl_w
        $error("ctrl_stat_bank: CTRL_W out of range 1..32");
    end

    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic [N_EVT-1:0]     irq_mask_q, irq_mask_d;
    logic [RD_DOUT_W-1:0] rd_dout_q, rd_dout_d;
    logic                 srq_q, srq_d;

    logic [N_EVT-1:0]     sticky, sticky_nxt, rd_clr;
    logic [CNT_W-1:0]     cnt [N_EVT];

    logic                 unused_tos;
    assign unused_tos = ^tos;

    for (genvar i = 0; i < N_EVT; i++) begin : g_chan
        assign rd_clr[i] = rd_stat && (rd_sel == RD_SEL_W'(i + 1));

        evt_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .cpu_clk      (cpu_clk),
            .rst          (rst),
            .evt_i        (evt_in[i]),
            .clr_i        (clr_sticky & tos[i]),
            .rd_clr_i     (rd_clr[i]),
            .sticky_o     (sticky[i]),
            .sticky_nxt_o (sticky_nxt[i]),
            .cnt_o        (cnt[i])
        );
    end

    always_comb begin
        ctrl_d     = wr_ctrl ? tos[CTRL_W-1:0] : ctrl_q;
        irq_mask_d = wr_mask ? tos[N_EVT-1:0]  : irq_mask_q;
        srq_d      = |(sticky_nxt & irq_mask_d);

        rd_dout_d = rd_dout_q;
        if (rd_stat) begin
            rd_dout_d = '0;
            if (rd_sel == RD_SEL_STICKY) begin
                rd_dout_d = RD_DOUT_W'(sticky);
            end
            for (int i = 0; i < N_EVT; i++) begin
                if (rd_sel == RD_SEL_W'(i + 1)) begin
                    rd_dout_d = RD_DOUT_W'(cnt[i]);
                end
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            irq_mask_q <= '0;
            rd_dout_q  <= '0;
            srq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            irq_mask_q <= irq_mask_d;
            rd_dout_q  <= rd_dout_d;
            srq_q      <= srq_d;
        end
    end

    assign ctrl    = ctrl_q;
    assign rd_dout = rd_dout_q;
    assign srq     = srq_q;

endmodule

// File: tb/tb_ctrl_stat_bank.sv
// Bench for ctrl_stat_bank (N_EVT=16, CNT_W=4): directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_ctrl_stat_bank;

    localparam int N_EVT  = 16;
    localparam int CNT_W  = 4;
    localparam int CTRL_W = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic        cpu_clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_ctrl = 1'b0, wr_mask = 1'b0, clr_sticky = 1'b0, rd_stat = 1'b0;
    logic [31:0] tos = '0;
    logic [15:0] evt_in = '0;
    logic [4:0]  rd_sel = '0;
    logic [15:0] ctrl, rd_dout;
    logic        srq;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_valid = 0;
    int          m_ctrl, m_mask, m_rd;
    bit          m_srq;
    bit   [15:0] m_st;
    int          m_cnt [N_EVT];

    ctrl_stat_bank #(.N_EVT(N_EVT), .CNT_W(CNT_W), .CTRL_W(CTRL_W)) dut (
        .cpu_clk    (cpu_clk),
        .rst        (rst),
        .wr_ctrl    (wr_ctrl),
        .wr_mask    (wr_mask),
        .clr_sticky (clr_sticky),
        .tos        (tos),
        .evt_in     (evt_in),
        .rd_stat    (rd_stat),
        .rd_sel     (rd_sel),
        .ctrl       (ctrl),
        .rd_dout    (rd_dout),
        .srq        (srq)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge cpu_clk) begin
        if (rst) begin
            m_ctrl = 0; m_mask = 0; m_rd = 0; m_srq = 0; m_st = '0;
            for (int i = 0; i < N_EVT; i++) m_cnt[i] = 0;
            m_valid = 1;
        end else begin
            if (rd_stat) begin
                if (rd_sel == 0)          m_rd = int'(m_st);
                else if (rd_sel <= N_EVT) m_rd = m_cnt[rd_sel - 1];
                else                      m_rd = 0;
            end
            for (int i = 0; i < N_EVT; i++) begin
                if (evt_in[i])                   m_st[i] = 1'b1;
                else if (clr_sticky && tos[i])   m_st[i] = 1'b0;
                if (rd_stat && rd_sel == i + 1)  m_cnt[i] = evt_in[i] ? 1 : 0;
                else if (evt_in[i])              m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
            end
            if (wr_ctrl) m_ctrl = int'(tos[15:0]);
            if (wr_mask) m_mask = int'(tos[15:0]);
            m_srq = (m_st & m_mask[15:0]) != 0;
        end
    end

    always @(negedge cpu_clk) begin
        if (m_valid) begin
            check("model_ctrl", {16'h0, ctrl}, m_ctrl);
            check("model_rd_dout", {16'h0, rd_dout}, m_rd);
            check("model_srq", {31'h0, srq}, {31'h0, m_srq});
        end
    end

    task automatic cyc();
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    task automatic quiet();
        wr_ctrl = 0; wr_mask = 0; clr_sticky = 0; rd_stat = 0; evt_in = '0;
    endtask

    task automatic rd(input int sel);
        quiet();
        rd_stat = 1; rd_sel = 5'(sel);
        cyc();
        rd_stat = 0;
    endtask

    initial begin
        // 1: reset ignores events and reads
        rst = 1; evt_in = '1; rd_stat = 1; rd_sel = 5'd3;
        repeat (3) cyc();
        check("rst_ctrl", {16'h0, ctrl}, 32'h0);
        check("rst_rd_dout", {16'h0, rd_dout}, 32'h0);
        check("rst_srq", {31'h0, srq}, 32'h0);
        rst = 0;
        rd(0);
        check("post_rst_sticky", {16'h0, rd_dout}, 32'h0);

        // 2: ctrl write
        quiet(); wr_ctrl = 1; tos = 32'h0000_A5C3; cyc();
        check("ctrl_write", {16'h0, ctrl}, 32'hA5C3);
        quiet(); tos = 32'h0000_FFFF; cyc();
        check("ctrl_hold", {16'h0, ctrl}, 32'hA5C3);

        // 3: saturation and read-to-clear
        quiet(); evt_in[2] = 1; repeat (20) cyc();
        rd(3);
        check("cnt_saturate", {16'h0, rd_dout}, 32'h000F);
        rd(3);
        check("cnt_rd_clear", {16'h0, rd_dout}, 32'h0);

        // 4: event coincident with read-clear is kept
        quiet(); evt_in[1] = 1; repeat (5) cyc();
        rd_stat = 1; rd_sel = 5'd2; cyc();
        check("rd_excl_evt", {16'h0, rd_dout}, 32'd5);
        rd(2);
        check("rd_kept_evt", {16'h0, rd_dout}, 32'd1);

        // 5: interrupt mask behaviour
        quiet(); clr_sticky = 1; tos = 32'hFFFF; cyc();
        quiet(); wr_mask = 1; tos = 32'h1; cyc();
        check("srq_idle", {31'h0, srq}, 32'h0);
        quiet(); evt_in[0] = 1; cyc();
        check("srq_raise", {31'h0, srq}, 32'h1);
        quiet(); clr_sticky = 1; tos = 32'h1; cyc();
        check("srq_drop", {31'h0, srq}, 32'h0);
        quiet(); evt_in[3] = 1; cyc();
        check("srq_unmasked", {31'h0, srq}, 32'h0);
        quiet(); evt_in[0] = 1; cyc();
        quiet(); evt_in[0] = 1; clr_sticky = 1; tos = 32'h1; cyc();
        check("srq_evt_wins", {31'h0, srq}, 32'h1);
        rd(0);
        check("sticky_evt_wins", {16'h0, rd_dout}, 32'h0009);
        rd(0);
        check("sticky_rd_noclr", {16'h0, rd_dout}, 32'h0009);

        // 6: out-of-range select and full sticky vector
        rd(N_EVT + 1);
        check("sel_oor", {16'h0, rd_dout}, 32'h0);
        quiet(); clr_sticky = 1; tos = 32'hFFFF; cyc();
        quiet(); evt_in = '1; cyc();
        rd(31);
        check("sel_max", {16'h0, rd_dout}, 32'h0);
        rd(0);
        check("sticky_all", {16'h0, rd_dout}, 32'hFFFF);

        // Reset mid-read discards the read
        quiet(); rd_stat = 1; rd_sel = 0; rst = 1; cyc();
        check("rst_mid_read", {16'h0, rd_dout}, 32'h0);
        rst = 0;

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            wr_ctrl    = ($urandom_range(0, 15) == 0);
            wr_mask    = ($urandom_range(0, 15) == 0);
            clr_sticky = ($urandom_range(0, 7) == 0);
            rd_stat    = ($urandom_range(0, 2) == 0);
            rd_sel     = 5'($urandom_range(0, 31) < 24 ? $urandom_range(0, N_EVT) : $urandom_range(0, 31));
            tos        = $urandom;
            evt_in     = 16'($urandom & $urandom);
            cyc();
        end
        quiet(); rst = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
